// File: rtl/simon_sound_if.sv
// Colour-select / tone-output bundle between the Simon game FSM and the tone generator.
// The master drives the colour; the slave returns the square wave and the tone in Hz.
interface simon_sound_if;
    logic [3:0] led_color;
    logic       sound;
    logic [9:0] frequency;

    modport master (
        output led_color,
        input  sound,
        input  frequency
    );

    modport slave (
        input  led_color,
        output sound,
        output frequency
    );
endinterface

// File: rtl/simon_sound.sv
// Simon Says tone generator: a one-hot colour select picks a game tone, and the
// block drives a 50%-duty square wave plus the tone in Hz, both registered.
module simon_sound #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned F_GREEN  = 415,
    parameter int unsigned F_RED    = 310,
    parameter int unsigned F_YELLOW = 252,
    parameter int unsigned F_BLUE   = 209
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    simon_sound_if.slave bus
);

    localparam int unsigned HP_GREEN  = CLK_HZ / (2 * F_GREEN);
    localparam int unsigned HP_RED    = CLK_HZ / (2 * F_RED);
    localparam int unsigned HP_YELLOW = CLK_HZ / (2 * F_YELLOW);
    localparam int unsigned HP_BLUE   = CLK_HZ / (2 * F_BLUE);

    localparam int unsigned HP_MAX_GR = (HP_GREEN > HP_RED) ? HP_GREEN : HP_RED;
    localparam int unsigned HP_MAX_YB = (HP_YELLOW > HP_BLUE) ? HP_YELLOW : HP_BLUE;
    localparam int unsigned HP_MAX    = (HP_MAX_GR > HP_MAX_YB) ? HP_MAX_GR : HP_MAX_YB;
    localparam int unsigned CNT_W     = $clog2(HP_MAX) + 1;

    // Tones must fit the 10-bit Hz output and give at least one cycle per half-period.
    if (F_GREEN == 0 || F_RED == 0 || F_YELLOW == 0 || F_BLUE == 0 ||
        F_GREEN >= 1024 || F_RED >= 1024 || F_YELLOW >= 1024 || F_BLUE >= 1024) begin : g_bad_tone
        $error("simon_sound: every tone must be in 1..1023 Hz");
    end
    if (HP_GREEN == 0 || HP_RED == 0 || HP_YELLOW == 0 || HP_BLUE == 0) begin : g_bad_clk
        $error("simon_sound: CLK_HZ too low for the highest tone");
    end

    typedef enum logic [2:0] {
        TONE_SILENT,
        TONE_GREEN,
        TONE_RED,
        TONE_YELLOW,
        TONE_BLUE
    } tone_e;

    function automatic tone_e decode_color(input logic [3:0] color);
        case (color)
            4'b0001: decode_color = TONE_GREEN;
            4'b0010: decode_color = TONE_RED;
            4'b0100: decode_color = TONE_YELLOW;
            4'b1000: decode_color = TONE_BLUE;
            default: decode_color = TONE_SILENT;
        endcase
    endfunction

    function automatic logic [9:0] tone_hz(input tone_e tone);
        case (tone)
            TONE_GREEN:  tone_hz = 10'(F_GREEN);
            TONE_RED:    tone_hz = 10'(F_RED);
            TONE_YELLOW: tone_hz = 10'(F_YELLOW);
            TONE_BLUE:   tone_hz = 10'(F_BLUE);
            default:     tone_hz = 10'd0;
        endcase
    endfunction

    // Terminal count of the half-period counter; unused while silent.
    function automatic logic [CNT_W-1:0] tone_last(input tone_e tone);
        case (tone)
            TONE_GREEN:  tone_last = CNT_W'(HP_GREEN - 1);
            TONE_RED:    tone_last = CNT_W'(HP_RED - 1);
            TONE_YELLOW: tone_last = CNT_W'(HP_YELLOW - 1);
            TONE_BLUE:   tone_last = CNT_W'(HP_BLUE - 1);
            default:     tone_last = '0;
        endcase
    endfunction

    tone_e            sel_q, sel_d;
    logic [9:0]       freq_q, freq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sound_q, sound_d;
    logic [CNT_W-1:0] last_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_q   <= TONE_SILENT;
            freq_q  <= 10'd0;
            cnt_q   <= '0;
            sound_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            freq_q  <= freq_d;
            cnt_q   <= cnt_d;
            sound_q <= sound_d;
        end
    end

    // A change of tone restarts the wave from the low phase on the same edge.
    always_comb begin
        sel_d    = decode_color(bus.led_color);
        freq_d   = tone_hz(sel_d);
        last_cnt = tone_last(sel_q);
        cnt_d    = cnt_q;
        sound_d  = sound_q;
        if (freq_d != freq_q) begin
            cnt_d   = '0;
            sound_d = 1'b0;
        end else if (freq_q == 10'd0) begin
            cnt_d   = '0;
            sound_d = 1'b0;
        end else if (cnt_q == last_cnt) begin
            cnt_d   = '0;
            sound_d = ~sound_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    assign bus.sound     = sound_q;
    assign bus.frequency = freq_q;

endmodule

// File: tb/tb_simon_sound.sv
// Self-checking bench for simon_sound: directed scenarios then random colour
// sequences, compared every cycle against an arithmetic tone/phase model.
module tb_simon_sound;

    localparam int unsigned CLK_HZ = 100_000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    simon_sound_if bus ();

    simon_sound #(
        .CLK_HZ (CLK_HZ)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;
    int mfreq        = 0;
    int mstart       = 0;

    function automatic int tone_of(input logic [3:0] color);
        case (color)
            4'b0001: return 415;
            4'b0010: return 310;
            4'b0100: return 252;
            4'b1000: return 209;
            default: return 0;
        endcase
    endfunction

    // Level after n cycles of a tone: low for the first half-period, then alternating.
    function automatic logic exp_sound();
        int hp;
        if (mfreq == 0) return 1'b0;
        hp = CLK_HZ / (2 * mfreq);
        return (((cycle - mstart) / hp) % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic edge_check(input string tag);
        int f;
        @(posedge clk);
        cycle++;
        f = tone_of(bus.led_color);
        if (f != mfreq) begin
            mfreq  = f;
            mstart = cycle;
        end
        #1;
        check({tag, ".freq"}, 32'(bus.frequency), 32'(mfreq));
        check({tag, ".sound"}, 32'(bus.sound), 32'(exp_sound()));
    endtask

    task automatic cyc(input logic [3:0] color, input string tag);
        @(negedge clk);
        bus.led_color = color;
        edge_check(tag);
    endtask

    task automatic hold(input logic [3:0] color, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(color, tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        mfreq = 0;
        #1;
        check({tag, ".async_freq"}, 32'(bus.frequency), 32'd0);
        check({tag, ".async_sound"}, 32'(bus.sound), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".held_freq"}, 32'(bus.frequency), 32'd0);
        check({tag, ".held_sound"}, 32'(bus.sound), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_check({tag, ".restart"});
    endtask

    initial begin
        logic [3:0] color;
        logic       prev;
        int         last_t;
        int         n;

        // Reset asserted before any clock edge.
        rst_n         = 1'b0;
        bus.led_color = 4'b0001;
        #1;
        check("reset.freq", 32'(bus.frequency), 32'd0);
        check("reset.sound", 32'(bus.sound), 32'd0);
        #20;
        check("reset_held.freq", 32'(bus.frequency), 32'd0);
        check("reset_held.sound", 32'(bus.sound), 32'd0);

        @(negedge clk);
        rst_n         = 1'b1;
        bus.led_color = 4'b0000;
        edge_check("release");

        // Green: first edge registers 415, then 120 low, 120 high, back low.
        cyc(4'b0001, "green_sel");
        check("green_sel.hz", 32'(bus.frequency), 32'd415);
        hold(4'b0001, 241, "green");

        cyc(4'b0010, "sweep_red");
        cyc(4'b0100, "sweep_yellow");
        cyc(4'b1000, "sweep_blue");
        check("sweep_blue.hz", 32'(bus.frequency), 32'd209);

        hold(4'b1111, 250, "multi_hot");
        hold(4'b0000, 250, "zero");

        // Blue held: measure spacing between successive toggles of the DUT output.
        prev   = bus.sound;
        last_t = -1;
        for (int i = 0; i < 2000; i++) begin
            cyc(4'b1000, "blue_hold");
            if (bus.sound !== prev) begin
                if (last_t >= 0)
                    check("blue_period", 32'(cycle - last_t), 32'(CLK_HZ / (2 * 209)));
                last_t = cycle;
                prev   = bus.sound;
            end
        end

        // Bounded wait for the high phase, then switch to red.
        n = 0;
        while (bus.sound !== 1'b1 && n < 600) begin
            cyc(4'b1000, "blue_wait");
            n++;
        end
        check("blue_high_reached", 32'(bus.sound), 32'd1);
        cyc(4'b0010, "switch");
        check("switch.hz", 32'(bus.frequency), 32'd310);
        check("switch.low", 32'(bus.sound), 32'd0);
        hold(4'b0010, 200, "red_after_switch");

        do_reset("mid_tone_reset");
        hold(4'b0010, 400, "red_after_reset");

        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 9) < 6) color = 4'b0001 << $urandom_range(0, 3);
            else                          color = 4'($urandom_range(0, 15));
            hold(color, int'($urandom_range(1, 500)), "random");
            if ($urandom_range(0, 9) == 0) do_reset("random_reset");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
